// File: rtl/rs_mon_pkg.sv
// Shared definitions for the symbol error monitor.
//   PCT_SCALE   : scale factor for percentages (100)
//   PCT_W       : width of a percentage result (0..100 fits in 7 bits)
//   div_state_t : state encoding of the iterative percentage divider
package rs_mon_pkg;

  localparam int PCT_SCALE = 100;
  localparam int PCT_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/pct_divider.sv
// Unsigned restoring divider producing a PCT_W-bit quotient, one quotient
// bit per cycle (MSB first).
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : synchronous abort back to IDLE
//   start     : sample num/den and begin (ignored unless IDLE)
//   num, den  : dividend / divisor; den == 0 yields quotient 0
//   busy      : high while not IDLE
//   done      : one-cycle strobe, quot valid during this cycle
//   quot      : quotient
// The caller guarantees num <= PCT_SCALE*den, so the quotient always fits
// in PCT_W bits and only PCT_W iterations are needed.
module pct_divider
  import rs_mon_pkg::*;
#(
  parameter int NUM_W = 17,
  parameter int DEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [PCT_W-1:0] quot
);

  localparam int WW = (NUM_W > DEN_W + PCT_W) ? NUM_W : DEN_W + PCT_W;
  localparam int BW = $clog2(PCT_W);

  div_state_t      state;
  logic [WW-1:0]   rem;
  logic [WW-1:0]   den_r;
  logic [BW-1:0]   bit_idx;
  logic [WW-1:0]   trial;

  assign trial = den_r << bit_idx;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rem     <= '0;
      den_r   <= '0;
      bit_idx <= '0;
      quot    <= '0;
    end else if (clear) begin
      state   <= IDLE;
      rem     <= '0;
      den_r   <= '0;
      bit_idx <= '0;
      quot    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rem     <= WW'(num);
            den_r   <= WW'(den);
            bit_idx <= BW'(PCT_W - 1);
            quot    <= '0;
            // A zero divisor would make every trial succeed; report 0.
            state   <= (den == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rem >= trial) begin
            rem           <= rem - trial;
            quot[bit_idx] <= 1'b1;
          end
          if (bit_idx == '0) state <= DONE;
          else               bit_idx <= bit_idx - BW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/symbol_error_monitor.sv
// Compares a generator symbol stream against a decoder symbol stream.
// Generator symbols are buffered in a reference FIFO; each decoder symbol
// pops one reference and the bit/symbol error of the pair enters a sliding
// window of the last WINDOW comparisons. Bit and symbol error percentages
// over the window are computed by two iterative dividers.
//   clk, rst              : clock, asynchronous active-low reset
//   clear                 : synchronous clear of all state
//   gen_valid/gen_sym     : generator symbol in; gen_ready = FIFO not full
//   dec_valid/dec_sym     : decoder symbol in
//   fifo_level            : reference symbols stored
//   window_fill           : comparisons currently in the window
//   bit_err_cnt/sym_err_cnt : error totals over the window
//   ber_pct/ser_pct       : floor percentages, updated with pct_valid strobe
//   overflow/underflow    : sticky push-while-full / pop-while-empty flags
module symbol_error_monitor
  import rs_mon_pkg::*;
#(
  parameter int SYM_W      = 8,
  parameter int FIFO_DEPTH = 128,
  parameter int WINDOW     = 100
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                gen_valid,
  input  logic [SYM_W-1:0]                    gen_sym,
  output logic                                gen_ready,
  input  logic                                dec_valid,
  input  logic [SYM_W-1:0]                    dec_sym,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic [7:0]                          window_fill,
  output logic [$clog2(WINDOW*SYM_W+1)-1:0]   bit_err_cnt,
  output logic [7:0]                          sym_err_cnt,
  output logic [PCT_W-1:0]                    ber_pct,
  output logic [PCT_W-1:0]                    ser_pct,
  output logic                                pct_valid,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int BE_W  = $clog2(WINDOW * SYM_W + 1);
  localparam int E_W   = $clog2(SYM_W + 1);
  localparam int WI_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SN_W  = $clog2(PCT_SCALE * WINDOW + 1);
  localparam int BN_W  = $clog2(PCT_SCALE * WINDOW * SYM_W + 1);

  // Reference FIFO
  logic [SYM_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign gen_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push      = gen_valid && gen_ready;
  // Emptiness is judged on the registered level: a same-cycle push cannot
  // feed a pop.
  assign pop       = dec_valid && (fifo_level != '0);

  // Error of the pair being compared this cycle
  logic [SYM_W-1:0] diff;
  logic [E_W-1:0]   e;
  logic             s;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // latch is inferred.
  always_comb begin
    diff = mem[rd_ptr] ^ dec_sym;
    e    = '0;
    for (int i = 0; i < SYM_W; i++) e = e + E_W'(diff[i]);
  end
  assign s = (e != '0);

  // Sliding window: circular store of per-comparison bit error counts.
  logic [E_W-1:0]  win_mem [WINDOW];
  logic [WI_W-1:0] win_idx;
  logic [E_W-1:0]  old_e;
  logic            old_s;
  logic            win_full;

  assign old_e    = win_mem[win_idx];
  assign old_s    = (old_e != '0);
  assign win_full = (window_fill == 8'(WINDOW));

  // NOTE: the storage arrays carry no reset; pointers, level and fill are
  // reset, so no entry is read before it has been written.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push) mem[wr_ptr]     <= gen_sym;
      if (pop)  win_mem[win_idx] <= e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      win_idx     <= '0;
      window_fill <= '0;
      bit_err_cnt <= '0;
      sym_err_cnt <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      win_idx     <= '0;
      window_fill <= '0;
      bit_err_cnt <= '0;
      sym_err_cnt <= '0;
    end else begin
      if (gen_valid && !gen_ready)          overflow  <= 1'b1;
      if (dec_valid && fifo_level == '0)    underflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: ;
      endcase

      if (pop) begin
        if (win_full) begin
          // Newest enters, oldest (about to be overwritten) leaves.
          bit_err_cnt <= bit_err_cnt + BE_W'(e) - BE_W'(old_e);
          sym_err_cnt <= sym_err_cnt + 8'(s) - 8'(old_s);
        end else begin
          bit_err_cnt <= bit_err_cnt + BE_W'(e);
          sym_err_cnt <= sym_err_cnt + 8'(s);
          window_fill <= window_fill + 8'd1;
        end
        win_idx <= (win_idx == WI_W'(WINDOW - 1)) ? '0 : win_idx + WI_W'(1);
      end
    end
  end

  // Percentage computation. upd_q marks the cycle in which freshly updated
  // counts are visible; an update arriving while the dividers are busy is
  // remembered in pending and served by one division on the latest counts.
  logic            upd_q, pending, div_start;
  logic            ber_busy, ser_busy, ber_done, ser_done;
  logic [PCT_W-1:0] ber_q, ser_q;
  logic [BN_W-1:0] ber_num;
  logic [BE_W-1:0] ber_den;
  logic [SN_W-1:0] ser_num;

  assign ber_num   = BN_W'(bit_err_cnt) * BN_W'(PCT_SCALE);
  assign ber_den   = BE_W'(window_fill) * BE_W'(SYM_W);
  assign ser_num   = SN_W'(sym_err_cnt) * SN_W'(PCT_SCALE);
  assign div_start = (pending || upd_q) && !(ber_busy || ser_busy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_q     <= 1'b0;
      pending   <= 1'b0;
      ber_pct   <= '0;
      ser_pct   <= '0;
      pct_valid <= 1'b0;
    end else if (clear) begin
      upd_q     <= 1'b0;
      pending   <= 1'b0;
      ber_pct   <= '0;
      ser_pct   <= '0;
      pct_valid <= 1'b0;
    end else begin
      upd_q     <= pop;
      pending   <= (pending || upd_q) && (ber_busy || ser_busy);
      pct_valid <= ber_done && ser_done;
      if (ber_done && ser_done) begin
        ber_pct <= ber_q;
        ser_pct <= ser_q;
      end
    end
  end

  pct_divider #(.NUM_W(BN_W), .DEN_W(BE_W)) u_ber_div (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .start (div_start),
    .num   (ber_num),
    .den   (ber_den),
    .busy  (ber_busy),
    .done  (ber_done),
    .quot  (ber_q)
  );

  pct_divider #(.NUM_W(SN_W), .DEN_W(8)) u_ser_div (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .start (div_start),
    .num   (ser_num),
    .den   (window_fill),
    .busy  (ser_busy),
    .done  (ser_done),
    .quot  (ser_q)
  );

endmodule

// File: tb/tb_symbol_error_monitor.sv
// Directed bench for symbol_error_monitor at default parameters. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_symbol_error_monitor;

  logic       clk = 1'b0;
  logic       rst, clear, gen_valid, dec_valid;
  logic [7:0] gen_sym, dec_sym;
  logic       gen_ready;
  logic [7:0] fifo_level;
  logic [7:0] window_fill;
  logic [9:0] bit_err_cnt;
  logic [7:0] sym_err_cnt;
  logic [6:0] ber_pct, ser_pct;
  logic       pct_valid, overflow, underflow;

  int total = 0;
  int bad   = 0;
  int pv_cnt = 0;
  int pv0;

  typedef struct {
    logic [7:0] g;
    logic [7:0] d;
    int         bit_exp;
    int         sym_exp;
    int         fill_exp;
  } vec_t;
  vec_t vecs[8];

  symbol_error_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .gen_valid   (gen_valid),
    .gen_sym     (gen_sym),
    .gen_ready   (gen_ready),
    .dec_valid   (dec_valid),
    .dec_sym     (dec_sym),
    .fifo_level  (fifo_level),
    .window_fill (window_fill),
    .bit_err_cnt (bit_err_cnt),
    .sym_err_cnt (sym_err_cnt),
    .ber_pct     (ber_pct),
    .ser_pct     (ser_pct),
    .pct_valid   (pct_valid),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pct_valid === 1'b1) pv_cnt++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic push(input logic [7:0] g);
    gen_valid = 1'b1; gen_sym = g;
    @(negedge clk);
    gen_valid = 1'b0;
  endtask

  task automatic pop(input logic [7:0] d);
    dec_valid = 1'b1; dec_sym = d;
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5,  0, 0, 1};
    vecs[1] = '{8'hFF, 8'h00,  8, 1, 2};
    vecs[2] = '{8'h0F, 8'h0E,  9, 2, 3};
    vecs[3] = '{8'h3C, 8'h3C,  9, 2, 4};
    vecs[4] = '{8'h80, 8'h00, 10, 3, 5};
    vecs[5] = '{8'h55, 8'hAA, 18, 4, 6};
    vecs[6] = '{8'h00, 8'h00, 18, 4, 7};
    vecs[7] = '{8'h12, 8'h13, 19, 5, 8};

    rst = 1'b0; clear = 1'b0; gen_valid = 1'b0; dec_valid = 1'b0;
    gen_sym = '0; dec_sym = '0;
    #12;
    check("rst gen_ready",   gen_ready,   1);
    check("rst fifo_level",  fifo_level,  0);
    check("rst window_fill", window_fill, 0);
    check("rst ber_pct",     ber_pct,     0);
    check("rst pct_valid",   pct_valid,   0);
    check("rst underflow",   underflow,   0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Ten identical pairs
    pv0 = pv_cnt;
    for (int i = 0; i < 10; i++) begin
      push(8'(i * 37));
      pop(8'(i * 37));
    end
    check("clean bit_err_cnt", bit_err_cnt, 0);
    check("clean sym_err_cnt", sym_err_cnt, 0);
    check("clean window_fill", window_fill, 10);
    wait_cyc(40);
    check("clean ber_pct", ber_pct, 0);
    check("clean ser_pct", ser_pct, 0);
    check("clean pct_valid seen", int'(pv_cnt > pv0), 1);

    // Table of single pairs, counts checked one cycle after each pop
    do_clear();
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].g);
      pop(vecs[i].d);
      check($sformatf("vec%0d bit_err_cnt", i), bit_err_cnt, vecs[i].bit_exp);
      check($sformatf("vec%0d sym_err_cnt", i), sym_err_cnt, vecs[i].sym_exp);
      check($sformatf("vec%0d window_fill", i), window_fill, vecs[i].fill_exp);
    end
    wait_cyc(40);
    check("vec ser_pct", ser_pct, 62);   // 500/8
    check("vec ber_pct", ber_pct, 29);   // 1900/64

    // Clear returns everything to idle values
    do_clear();
    check("clear window_fill", window_fill, 0);
    check("clear bit_err_cnt", bit_err_cnt, 0);
    check("clear ser_pct",     ser_pct,     0);
    check("clear ber_pct",     ber_pct,     0);

    // Four pairs, third differs in two bits
    push(8'h11); pop(8'h11);
    push(8'h22); pop(8'h22);
    push(8'h33); pop(8'h30);
    push(8'h44); pop(8'h44);
    check("four bit_err_cnt", bit_err_cnt, 2);
    check("four sym_err_cnt", sym_err_cnt, 1);
    wait_cyc(40);
    check("four ser_pct", ser_pct, 25);
    check("four ber_pct", ber_pct, 6);

    // Full window of single-bit errors, then a full window of clean pairs
    do_clear();
    for (int i = 0; i < 100; i++) push(8'(i));
    for (int i = 0; i < 100; i++) pop(8'(i) ^ 8'h01);
    wait_cyc(40);
    check("err100 sym_err_cnt", sym_err_cnt, 100);
    check("err100 bit_err_cnt", bit_err_cnt, 100);
    check("err100 ser_pct",     ser_pct,     100);
    check("err100 ber_pct",     ber_pct,     12);
    for (int i = 0; i < 100; i++) push(8'(i + 3));
    for (int i = 0; i < 100; i++) pop(8'(i + 3));
    wait_cyc(40);
    check("clean100 bit_err_cnt", bit_err_cnt, 0);
    check("clean100 sym_err_cnt", sym_err_cnt, 0);
    check("clean100 window_fill", window_fill, 100);
    check("clean100 ser_pct",     ser_pct,     0);
    check("clean100 ber_pct",     ber_pct,     0);

    // Fill the FIFO, then one push too many
    do_clear();
    for (int i = 0; i < 128; i++) begin
      push(8'(i));
      if (i == 126) check("fifo127 gen_ready", gen_ready, 1);
    end
    check("full gen_ready",  gen_ready,  0);
    check("full fifo_level", fifo_level, 128);
    check("full overflow",   overflow,   0);
    push(8'hEE);
    check("ovf overflow",   overflow,   1);
    check("ovf fifo_level", fifo_level, 128);
    for (int i = 0; i < 128; i++) pop(8'(i));
    check("drain fifo_level",  fifo_level,  0);
    check("drain bit_err_cnt", bit_err_cnt, 0);
    check("drain window_fill", window_fill, 100);
    check("drain underflow",   underflow,   0);

    // Pop on empty FIFO with simultaneous push
    do_clear();
    wait_cyc(20);
    pv0 = pv_cnt;
    gen_valid = 1'b1; gen_sym = 8'h05; dec_valid = 1'b1; dec_sym = 8'hFA;
    @(negedge clk);
    gen_valid = 1'b0; dec_valid = 1'b0;
    check("empty underflow",   underflow,   1);
    check("empty fifo_level",  fifo_level,  1);
    check("empty window_fill", window_fill, 0);
    check("empty bit_err_cnt", bit_err_cnt, 0);
    wait_cyc(20);
    check("empty no pct_valid", pv_cnt - pv0, 0);

    // Reset while the dividers are running
    do_clear();
    push(8'h0F);
    pop(8'h00);            // 4 bit errors -> would give ber 50, ser 100
    wait_cyc(3);
    pv0 = pv_cnt;
    #1 rst = 1'b0;
    #1;
    check("arst window_fill", window_fill, 0);
    check("arst bit_err_cnt", bit_err_cnt, 0);
    check("arst sym_err_cnt", sym_err_cnt, 0);
    check("arst pct_valid",   pct_valid,   0);
    check("arst gen_ready",   gen_ready,   1);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(40);
    check("arst no pct_valid", pv_cnt - pv0, 0);
    check("arst ber_pct", ber_pct, 0);
    check("arst ser_pct", ser_pct, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/symbol_error_monitor.md
SYMBOL_ERROR_MONITOR -- requirements
Module: symbol_error_monitor

Interface
REQ-001 Parameter SYM_W, default 8: symbol width in bits (1..16).
REQ-002 Parameter FIFO_DEPTH, default 128: reference FIFO depth, power of 2, 4..1024.
REQ-003 Parameter WINDOW, default 100: sliding comparison window in symbols, 1..255.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all state.
- gen_valid  in  1  generator symbol present.
- gen_sym  in  SYM_W  generator symbol.
- gen_ready  out  1  FIFO not full.
- dec_valid  in  1  decoder symbol present.
- dec_sym  in  SYM_W  decoder symbol.
- fifo_level  out  clog2(FIFO_DEPTH+1)  stored symbol count.
- window_fill  out  8  symbols currently in window.
- bit_err_cnt  out  clog2(WINDOW*SYM_W+1)  bit errors in window.
- sym_err_cnt  out  8  symbol errors in window.
- ber_pct  out  7  bit error percentage.
- ser_pct  out  7  symbol error percentage.
- pct_valid  out  1  one-cycle strobe when percentages update.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Function
REQ-005 Push when gen_valid and gen_ready; gen_ready = fifo_level < FIFO_DEPTH.
REQ-006 gen_valid while full SHALL drop the symbol, set overflow, leave FIFO unchanged.
REQ-007 Pop when dec_valid and fifo_level > 0 at cycle start; no same-cycle bypass: dec_valid on empty FIFO sets underflow even with simultaneous push, and no comparison occurs.
REQ-008 Simultaneous push and pop SHALL both execute; fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-009 On pop, popped symbol XOR dec_sym SHALL give e = popcount (0..SYM_W) and s = (e != 0).
REQ-010 Window SHALL hold last WINDOW (e, s) entries; bit_err_cnt, sym_err_cnt, window_fill update the cycle after the pop (latency 1).
REQ-011 While window_fill < WINDOW, new entry adds and window_fill increments; once full, new entry adds and oldest subtracts in the same cycle.
REQ-012 ser_pct = floor(100*sym_err_cnt/window_fill); ber_pct = floor(100*bit_err_cnt/(window_fill*SYM_W)); both 0 when window_fill = 0.
REQ-013 Percentages SHALL come from an iterative divider (one quotient bit per cycle, at most 16 cycles); counter update starts a division; pct_valid pulses when ber_pct and ser_pct load together.
REQ-014 Update during division SHALL set a pending flag; on completion results load and one new division starts on latest counts; intermediate updates coalesce, final values always reflect last counts.
REQ-015 clear SHALL return all state to reset values in the next cycle, overriding push/pop that cycle.

Reset
REQ-016 rst low SHALL immediately force: FIFO empty, pointers 0, window empty, all counts 0, ber_pct/ser_pct 0, pct_valid 0, overflow/underflow 0, gen_ready 1, divider idle, pending 0.
REQ-017 Reset mid-division SHALL abort it; no pct_valid after release until a new comparison.

Structure
REQ-018 Shared package rs_mon_pkg holds percentage constant (100), percentage width (7), divider state enum (IDLE, RUN, DONE).
REQ-019 Divider SHALL be sub-module pct_divider (start/busy/done handshake, unsigned restoring), instantiated twice or time-shared; all else in one module.

Verification (default parameters)
REQ-020 10 identical symbol pairs -> bit_err_cnt 0, sym_err_cnt 0, window_fill 10, ber_pct 0, ser_pct 0.
REQ-021 4 pairs, third differs in 2 bits -> bit_err_cnt 2, sym_err_cnt 1, ser_pct 25, ber_pct 6.
REQ-022 100 pairs each with 1 bit error, then 100 clean -> after first 100: ser_pct 100, ber_pct 12; after next 100: both 0, window_fill 100.
REQ-023 129 pushes, no pops -> gen_ready low after 128th, fifo_level 128, overflow 1; 129th symbol never compared.
REQ-024 dec_valid on empty FIFO with simultaneous gen_valid -> underflow 1, counts unchanged, fifo_level 1.
REQ-025 rst low during divider RUN -> all outputs at reset values, no pct_valid pulse after release.
